// File: rtl/mem_stage_dmem_if.sv
// Memory-stage request/response bundle between the EXE/MEM register
// and the data-memory responder.
interface mem_stage_dmem_if;
   logic [31:0] ALUResult_M;
   logic [31:0] WriteData_M;
   logic        MemWrite_M;
   logic        MemtoReg_M;
   logic [31:0] ReadData_M;
   logic        Stall_M;
   logic        Done_M;
   logic        AddrErr_M;

   modport master (
      output ALUResult_M,
      output WriteData_M,
      output MemWrite_M,
      output MemtoReg_M,
      input  ReadData_M,
      input  Stall_M,
      input  Done_M,
      input  AddrErr_M
   );

   modport slave (
      input  ALUResult_M,
      input  WriteData_M,
      input  MemWrite_M,
      input  MemtoReg_M,
      output ReadData_M,
      output Stall_M,
      output Done_M,
      output AddrErr_M
   );
endinterface

// File: rtl/mem_stage_dmem.sv
// Multi-cycle word data memory for the MEM stage.
// Holds the pipeline via Stall_M until the access completes.
module mem_stage_dmem #(
   parameter int ADDR_W  = 6,
   parameter int LATENCY = 2
) (
   input  logic            clk,
   input  logic            rst,
   mem_stage_dmem_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       data;
   logic              wr;
   logic              err;
   logic [31:0]       rdata;
   logic [31:0]       mem [2**ADDR_W];

   logic              req;
   logic              aligned;
   logic [ADDR_W-1:0] idx_in;
   logic              last;
   logic              mem_we;
   logic              unused_hi;

   assign req     = bus.MemWrite_M | bus.MemtoReg_M;
   assign aligned = (bus.ALUResult_M[1:0] == 2'b00);
   assign idx_in  = bus.ALUResult_M[ADDR_W+1:2];
   assign last    = (state == BUSY) && (cnt == '0);
   assign mem_we  = last && wr && !rst;

   // Upper address bits are dropped, so addresses wrap.
   assign unused_hi = ^bus.ALUResult_M[31:ADDR_W+2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         data  <= '0;
         wr    <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req && aligned) begin
                  idx   <= idx_in;
                  data  <= bus.WriteData_M;
                  wr    <= bus.MemWrite_M;
                  cnt   <= CNT_INIT;
                  state <= BUSY;
               end else if (req) begin
                  err   <= 1'b1;
                  state <= DONE;
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  if (!wr) rdata <= mem[idx];
                  err   <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= data;
   end

   assign bus.ReadData_M = rdata;
   assign bus.Stall_M    = ((state == IDLE) && req) || (state == BUSY);
   assign bus.Done_M     = (state == DONE);
   assign bus.AddrErr_M  = (state == DONE) && err;

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed bench for mem_stage_dmem: LATENCY=2 main instance
// plus a LATENCY=1 instance for the back-to-back sweep.
module tb_mem_stage_dmem;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mem_stage_dmem_if d2();
   mem_stage_dmem_if d1();

   mem_stage_dmem #(.ADDR_W(6), .LATENCY(2)) u2 (
      .clk(clk),
      .rst(rst),
      .bus(d2.slave)
   );

   mem_stage_dmem #(.ADDR_W(6), .LATENCY(1)) u1 (
      .clk(clk),
      .rst(rst),
      .bus(d1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one access on d2 starting in an IDLE cycle; returns the
   // observed stall count, Done cycle (-1 on timeout), error and data.
   task automatic run_access(
      input  logic [31:0] a,
      input  logic [31:0] d,
      input  logic        we,
      input  logic        re,
      output int          stalls,
      output int          done_cyc,
      output logic        err,
      output logic [31:0] rd
   );
      stalls   = 0;
      done_cyc = -1;
      err      = 1'b0;
      rd       = '0;
      d2.ALUResult_M = a;
      d2.WriteData_M = d;
      d2.MemWrite_M  = we;
      d2.MemtoReg_M  = re;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (d2.Stall_M) stalls++;
         if (d2.Done_M) begin
            done_cyc = c;
            err      = d2.AddrErr_M;
            rd       = d2.ReadData_M;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      d2.MemWrite_M = 1'b0;
      d2.MemtoReg_M = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      d2.ALUResult_M = '0;
      d2.WriteData_M = '0;
      d2.MemWrite_M  = 1'b0;
      d2.MemtoReg_M  = 1'b0;
      d1.ALUResult_M = '0;
      d1.WriteData_M = '0;
      d1.MemWrite_M  = 1'b0;
      d1.MemtoReg_M  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (d2.Stall_M !== 1'b0) begin
         errors++; $display("FAIL rst_stall2 got %b want 0", d2.Stall_M);
      end
      checks++;
      if (d2.Done_M !== 1'b0) begin
         errors++; $display("FAIL rst_done2 got %b want 0", d2.Done_M);
      end
      checks++;
      if (d2.AddrErr_M !== 1'b0) begin
         errors++; $display("FAIL rst_err2 got %b want 0", d2.AddrErr_M);
      end
      checks++;
      if (d2.ReadData_M !== 32'h0) begin
         errors++; $display("FAIL rst_rd2 got %h want 0", d2.ReadData_M);
      end
      checks++;
      if (d1.Stall_M !== 1'b0 || d1.Done_M !== 1'b0) begin
         errors++; $display("FAIL rst_ctl1 got %b%b want 00", d1.Stall_M, d1.Done_M);
      end
      checks++;
      if (d1.ReadData_M !== 32'h0) begin
         errors++; $display("FAIL rst_rd1 got %h want 0", d1.ReadData_M);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store_load();
      int          st;
      int          dc;
      logic        er;
      logic [31:0] rd;
      run_access(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, st, dc, er, rd);
      checks++;
      if (st != 3) begin
         errors++; $display("FAIL st_stall got %0d want 3", st);
      end
      checks++;
      if (dc != 3) begin
         errors++; $display("FAIL st_done got %0d want 3", dc);
      end
      checks++;
      if (er !== 1'b0) begin
         errors++; $display("FAIL st_err got %b want 0", er);
      end
      @(negedge clk);
      checks++;
      if (d2.Done_M !== 1'b0) begin
         errors++; $display("FAIL st_pulse got %b want 0", d2.Done_M);
      end
      @(posedge clk); #1;
      run_access(32'h10, 32'h0, 1'b0, 1'b1, st, dc, er, rd);
      checks++;
      if (dc != 3 || st != 3) begin
         errors++; $display("FAIL ld_timing got %0d/%0d want 3/3", dc, st);
      end
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         errors++; $display("FAIL ld_data got %h want deadbeef", rd);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (d2.ReadData_M !== 32'hDEADBEEF) begin
         errors++; $display("FAIL ld_hold got %h want deadbeef", d2.ReadData_M);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_misaligned();
      int          st;
      int          dc;
      logic        er;
      logic [31:0] rd;
      run_access(32'h13, 32'h1, 1'b1, 1'b0, st, dc, er, rd);
      checks++;
      if (st != 1) begin
         errors++; $display("FAIL mis_stall got %0d want 1", st);
      end
      checks++;
      if (dc != 1) begin
         errors++; $display("FAIL mis_done got %0d want 1", dc);
      end
      checks++;
      if (er !== 1'b1) begin
         errors++; $display("FAIL mis_err got %b want 1", er);
      end
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         errors++; $display("FAIL mis_rd got %h want deadbeef", rd);
      end
      run_access(32'h10, 32'h0, 1'b0, 1'b1, st, dc, er, rd);
      checks++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
         errors++; $display("FAIL mis_reload got %h/%b want deadbeef/0", rd, er);
      end
   endtask

   task automatic test_wrap();
      int          st;
      int          dc;
      logic        er;
      logic [31:0] rd;
      run_access(32'h100, 32'hA5A5A5A5, 1'b1, 1'b0, st, dc, er, rd);
      run_access(32'h000, 32'h0, 1'b0, 1'b1, st, dc, er, rd);
      checks++;
      if (rd !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL wrap_rd got %h want a5a5a5a5", rd);
      end
   endtask

   task automatic test_conflict();
      int          st;
      int          dc;
      logic        er;
      logic [31:0] rd;
      run_access(32'h20, 32'h55, 1'b1, 1'b1, st, dc, er, rd);
      checks++;
      if (st != 3 || dc != 3) begin
         errors++; $display("FAIL cf_timing got %0d/%0d want 3/3", st, dc);
      end
      checks++;
      if (rd !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL cf_rd got %h want a5a5a5a5", rd);
      end
      run_access(32'h20, 32'h0, 1'b0, 1'b1, st, dc, er, rd);
      checks++;
      if (rd !== 32'h55) begin
         errors++; $display("FAIL cf_load got %h want 55", rd);
      end
   endtask

   task automatic test_reset_mid();
      int          st;
      int          dc;
      logic        er;
      logic [31:0] rd;
      run_access(32'h30, 32'h11, 1'b1, 1'b0, st, dc, er, rd);
      d2.ALUResult_M = 32'h30;
      d2.WriteData_M = 32'h77;
      d2.MemWrite_M  = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (d2.Done_M !== 1'b0) begin
         errors++; $display("FAIL rm_busy_done got %b want 0", d2.Done_M);
      end
      d2.MemWrite_M = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (d2.Done_M !== 1'b0 || d2.AddrErr_M !== 1'b0) begin
         errors++; $display("FAIL rm_done got %b%b want 00", d2.Done_M, d2.AddrErr_M);
      end
      checks++;
      if (d2.Stall_M !== 1'b0) begin
         errors++; $display("FAIL rm_stall got %b want 0", d2.Stall_M);
      end
      checks++;
      if (d2.ReadData_M !== 32'h0) begin
         errors++; $display("FAIL rm_rd got %h want 0", d2.ReadData_M);
      end
      @(posedge clk); #1;
      run_access(32'h30, 32'h0, 1'b0, 1'b1, st, dc, er, rd);
      checks++;
      if (rd !== 32'h11) begin
         errors++; $display("FAIL rm_load got %h want 11", rd);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_st;
      logic exp_dn;
      d1.ALUResult_M = 32'h8;
      d1.WriteData_M = 32'hCAFE0001;
      for (int c = 0; c < 9; c++) begin
         d1.MemWrite_M = (c < 3);
         d1.MemtoReg_M = (c >= 3);
         exp_st = (c % 3 != 2);
         exp_dn = (c % 3 == 2);
         @(negedge clk);
         checks++;
         if (d1.Stall_M !== exp_st) begin
            errors++; $display("FAIL b2b_stall c%0d got %b want %b", c, d1.Stall_M, exp_st);
         end
         checks++;
         if (d1.Done_M !== exp_dn) begin
            errors++; $display("FAIL b2b_done c%0d got %b want %b", c, d1.Done_M, exp_dn);
         end
         if (c >= 3 && exp_dn) begin
            checks++;
            if (d1.ReadData_M !== 32'hCAFE0001) begin
               errors++; $display("FAIL b2b_rd c%0d got %h want cafe0001", c, d1.ReadData_M);
            end
         end
         @(posedge clk); #1;
      end
      d1.MemWrite_M = 1'b0;
      d1.MemtoReg_M = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_store_load();
      test_misaligned();
      test_wrap();
      test_conflict();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
